// File: rtl/gpio_pkg.sv
// Shared defaults and pad drive encoding for the GPIO pad bank.
package gpio_pkg;

    localparam int GPIO_WIDTH       = 32;
    localparam int GPIO_SYNC_STAGES = 2;
    localparam int GPIO_FILTER_BITS = 4;

    typedef enum logic {
        PIN_PUSH_PULL  = 1'b0,
        PIN_OPEN_DRAIN = 1'b1
    } pin_mode_e;

    // One pin's IOBUF controls; t = 1 releases the pad to hi-Z.
    typedef struct packed {
        logic o;
        logic t;
    } pad_drive_t;

    // Open-drain pins only ever pull low; a written 1 releases the pad.
    function automatic pad_drive_t pad_drive(pin_mode_e mode, logic we, logic wr);
        pad_drive_t d;
        if (mode == PIN_OPEN_DRAIN) begin
            d.o = 1'b0;
            d.t = ~(we & ~wr);
        end else begin
            d.o = wr;
            d.t = ~we;
        end
        return d;
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin of input path: synchroniser chain, glitch-filter counter, stable level.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int FILTER_BITS = GPIO_FILTER_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_pad,
    input  logic                   i_bypass,
    input  logic                   i_filt_en,
    input  logic [FILTER_BITS-1:0] i_filt_len,
    output logic                   o_sync,
    output logic                   o_stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILTER_BITS-1:0] r_cnt;
    logic                   r_stable;
    logic                   w_s;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign o_sync   = w_s;
    assign o_stable = r_stable;

    // Metastability chain: pad level shifts in at bit 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
    end

    // Accept a new level only after it has differed for filt_len+1 cycles in a row.
    // Using >= lets a shortened filt_len take effect on the next differing cycle
    // without the counter ever wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (i_bypass || !i_filt_en) begin
            r_stable <= w_s;
            r_cnt    <= '0;
        end else if (w_s == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt >= i_filt_len) begin
            r_stable <= w_s;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_pad_bank.sv
// GPIO pad-side bank: registered tristate drive, filtered inputs, edge interrupts.
module gpio_pad_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int FILTER_BITS = GPIO_FILTER_BITS
) (
    input  logic                   io_clock,
    input  logic                   io_reset,
    input  logic [WIDTH-1:0]       pad_i,
    output logic [WIDTH-1:0]       pad_o,
    output logic [WIDTH-1:0]       pad_t,
    input  logic [WIDTH-1:0]       pins_write,
    input  logic [WIDTH-1:0]       pins_writeEnable,
    output logic [WIDTH-1:0]       pins_read,
    input  logic [WIDTH-1:0]       cfg_openDrain,
    input  logic [WIDTH-1:0]       cfg_filtEn,
    input  logic [FILTER_BITS-1:0] cfg_filtLen,
    input  logic [WIDTH-1:0]       cfg_riseEn,
    input  logic [WIDTH-1:0]       cfg_fallEn,
    input  logic [WIDTH-1:0]       irq_clear,
    output logic [WIDTH-1:0]       irq_pending,
    output logic                   irq
);

    localparam int                   WARM_CYCLES = SYNC_STAGES + 1;
    localparam int                   WARM_BITS   = $clog2(WARM_CYCLES + 1);
    localparam logic [WARM_BITS-1:0] WARM_LAST   = WARM_BITS'(WARM_CYCLES);

    logic [WARM_BITS-1:0] r_warm_cnt;
    logic                 w_warm;
    logic [WIDTH-1:0]     w_sync, w_stable, w_rise, w_fall;
    logic [WIDTH-1:0]     r_prev, r_pending;
    logic [WIDTH-1:0]     r_pad_o, r_pad_t, w_pad_o_nxt, w_pad_t_nxt;

    assign w_warm      = (r_warm_cnt != WARM_LAST);
    assign w_rise      = w_stable & ~r_prev;
    assign w_fall      = ~w_stable & r_prev;
    assign pad_o       = r_pad_o;
    assign pad_t       = r_pad_t;
    assign pins_read   = w_stable;
    assign irq_pending = r_pending;
    assign irq         = |r_pending;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            gpio_pin_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_BITS (FILTER_BITS)
            ) u_filt (
                .i_clk      (io_clock),
                .i_rst      (io_reset),
                .i_pad      (pad_i[gi]),
                .i_bypass   (w_warm),
                .i_filt_en  (cfg_filtEn[gi]),
                .i_filt_len (cfg_filtLen),
                .o_sync     (w_sync[gi]),
                .o_stable   (w_stable[gi])
            );
        end
    endgenerate

    // Per-pin pad drive decoded from SoC request and pin mode.
    always_comb begin
        w_pad_o_nxt = '0;
        w_pad_t_nxt = '1;
        for (int i = 0; i < WIDTH; i++) begin
            {w_pad_o_nxt[i], w_pad_t_nxt[i]} =
                pad_drive(pin_mode_e'(cfg_openDrain[i]), pins_writeEnable[i], pins_write[i]);
        end
    end

    // Output registers; reset releases every pad to hi-Z.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            r_pad_o <= '0;
            r_pad_t <= '1;
        end else begin
            r_pad_o <= w_pad_o_nxt;
            r_pad_t <= w_pad_t_nxt;
        end
    end

    // Warm-up window after reset release while the sync chain fills.
    always_ff @(posedge io_clock) begin
        if (io_reset)    r_warm_cnt <= '0;
        else if (w_warm) r_warm_cnt <= r_warm_cnt + 1'b1;
    end

    // Edge history and sticky pending flags; a set beats a same-cycle clear.
    // During warm-up prev follows the value stable is being loaded with, so a
    // pin idling high does not look like a rising edge once warm-up ends.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else if (w_warm) begin
            r_prev    <= w_sync;
            r_pending <= r_pending & ~irq_clear;
        end else begin
            r_prev    <= w_stable;
            r_pending <= (r_pending & ~irq_clear) | (w_rise & cfg_riseEn) | (w_fall & cfg_fallEn);
        end
    end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Scoreboard bench for gpio_pad_bank: driver pushes model expectations, monitor compares.
module tb_gpio_pad_bank;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int FB = 4;

    logic          io_clock = 1'b0;
    logic          io_reset;
    logic [W-1:0]  pad_i, pad_o, pad_t;
    logic [W-1:0]  pins_write, pins_writeEnable, pins_read;
    logic [W-1:0]  cfg_openDrain, cfg_filtEn, cfg_riseEn, cfg_fallEn;
    logic [FB-1:0] cfg_filtLen;
    logic [W-1:0]  irq_clear, irq_pending;
    logic          irq;

    always #5 io_clock = ~io_clock;

    gpio_pad_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_BITS(FB)) dut (
        .io_clock         (io_clock),
        .io_reset         (io_reset),
        .pad_i            (pad_i),
        .pad_o            (pad_o),
        .pad_t            (pad_t),
        .pins_write       (pins_write),
        .pins_writeEnable (pins_writeEnable),
        .pins_read        (pins_read),
        .cfg_openDrain    (cfg_openDrain),
        .cfg_filtEn       (cfg_filtEn),
        .cfg_filtLen      (cfg_filtLen),
        .cfg_riseEn       (cfg_riseEn),
        .cfg_fallEn       (cfg_fallEn),
        .irq_clear        (irq_clear),
        .irq_pending      (irq_pending),
        .irq              (irq)
    );

    typedef struct {
        logic [W-1:0] po, pt, pr, pend;
        logic         irq;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    // Reference model: pad samples in a delay line, filter as a run length of
    // consecutive disagreeing samples, pending as sticky edge flags.
    logic [W-1:0] m_hist[SS];
    logic [W-1:0] m_stable, m_prev, m_pend, m_po, m_pt;
    int           m_run[W];
    int           m_warm;

    task automatic model_edge();
        logic [W-1:0] s, rise, fall, st_n;
        bit warm;
        exp_t e;
        if (io_reset) begin
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_stable = '0; m_prev = '0; m_pend = '0;
            m_po = '0; m_pt = '1; m_warm = 0;
        end else begin
            m_po = pins_write & ~cfg_openDrain;
            m_pt = ~(pins_writeEnable & ~(cfg_openDrain & pins_write));
            s = m_hist[SS-1];
            for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pad_i;
            warm = (m_warm < SS + 1);
            rise = m_stable & ~m_prev;
            fall = ~m_stable & m_prev;
            if (warm) begin
                m_pend = m_pend & ~irq_clear;
                m_prev = s;
            end else begin
                m_pend = (m_pend & ~irq_clear) | (rise & cfg_riseEn) | (fall & cfg_fallEn);
                m_prev = m_stable;
            end
            st_n = m_stable;
            for (int i = 0; i < W; i++) begin
                if (warm || !cfg_filtEn[i]) begin
                    st_n[i] = s[i];
                    m_run[i] = 0;
                end else if (s[i] == m_stable[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] > int'(cfg_filtLen)) begin
                        st_n[i] = s[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_stable = st_n;
            if (warm) m_warm++;
        end
        e.po = m_po; e.pt = m_pt; e.pr = m_stable; e.pend = m_pend; e.irq = |m_pend;
        q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(negedge io_clock);
        cyc++;
    endtask

    function automatic void cmp(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endfunction

    // Monitor: every edge the DUT presents fresh outputs; compare against oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge io_clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("sb_pad_o", pad_o, e.po);
                cmp("sb_pad_t", pad_t, e.pt);
                cmp("sb_pins_read", pins_read, e.pr);
                cmp("sb_irq_pending", irq_pending, e.pend);
                cmp("sb_irq", W'(irq), W'(e.irq));
            end
        end
    end

    initial begin
        io_reset = 1'b1; pad_i = '1;
        pins_write = '0; pins_writeEnable = '0; cfg_openDrain = '0;
        cfg_filtEn = '0; cfg_filtLen = '0; cfg_riseEn = '0; cfg_fallEn = '0;
        irq_clear = '0;
        @(negedge io_clock);

        // Reset with pins idling high
        step(); step();
        cmp("rst_pad_t", pad_t, '1);
        cmp("rst_pins_read", pins_read, '0);
        io_reset = 1'b0;
        step(); step();
        cmp("t1_read_early", pins_read, '0);
        step();
        cmp("t1_read", pins_read, '1);
        repeat (4) step();
        cmp("t1_no_pend", irq_pending, '0);
        cmp("t1_pad_t", pad_t, '1);

        // Open-drain pin 0
        pins_writeEnable[0] = 1'b1; pins_write[0] = 1'b0; cfg_openDrain[0] = 1'b1;
        cmp("t2_latency", W'(pad_t[0]), W'(1'b1));
        step();
        cmp("t2_t_low", W'(pad_t[0]), W'(1'b0));
        cmp("t2_o_low", W'(pad_o[0]), W'(1'b0));
        pins_write[0] = 1'b1;
        step();
        cmp("t2_t_high", W'(pad_t[0]), W'(1'b1));
        cmp("t2_o_high", W'(pad_o[0]), W'(1'b0));

        // Glitch filter on pin 3, length 3
        cfg_filtLen = 4'd3;
        pad_i[3] = 1'b0;
        repeat (4) step();
        cmp("t3_low", W'(pins_read[3]), W'(1'b0));
        cfg_filtEn[3] = 1'b1;
        step();
        pad_i[3] = 1'b1;
        repeat (3) step();
        pad_i[3] = 1'b0;
        repeat (8) step();
        cmp("t3_short", W'(pins_read[3]), W'(1'b0));
        pad_i[3] = 1'b1;
        repeat (4) step();
        pad_i[3] = 1'b0;
        step();
        cmp("t3_long_early", W'(pins_read[3]), W'(1'b0));
        step();
        cmp("t3_long", W'(pins_read[3]), W'(1'b1));
        repeat (8) step();

        // Rising-edge interrupt on pin 5
        cfg_riseEn[5] = 1'b1;
        pad_i[5] = 1'b0;
        repeat (5) step();
        cmp("t4_fall_masked", W'(irq_pending[5]), W'(1'b0));
        pad_i[5] = 1'b1;
        repeat (3) step();
        cmp("t4_read_rise", W'(pins_read[5]), W'(1'b1));
        cmp("t4_pend_early", W'(irq_pending[5]), W'(1'b0));
        step();
        cmp("t4_pend", W'(irq_pending[5]), W'(1'b1));
        cmp("t4_irq", W'(irq), W'(1'b1));
        pad_i[5] = 1'b0;
        repeat (6) step();
        cmp("t4_pend_hold", W'(irq_pending[5]), W'(1'b1));
        irq_clear[5] = 1'b1;
        step();
        irq_clear[5] = 1'b0;
        cmp("t4_cleared", W'(irq_pending[5]), W'(1'b0));
        cmp("t4_irq_low", W'(irq), W'(1'b0));

        // Clear in the same cycle as a new rise: set wins
        pad_i[5] = 1'b1;
        repeat (3) step();
        irq_clear[5] = 1'b1;
        step();
        irq_clear[5] = 1'b0;
        cmp("t5_set_wins", W'(irq_pending[5]), W'(1'b1));

        // Reset mid filter count with pending set and a pad driven
        pins_write[0] = 1'b0;
        pad_i[3] = 1'b1;
        repeat (3) step();
        cmp("t6_pre_drive", W'(pad_t[0]), W'(1'b0));
        cmp("t6_pre_pend", W'(irq_pending[5]), W'(1'b1));
        io_reset = 1'b1;
        step();
        cmp("t6_pad_t", pad_t, '1);
        cmp("t6_pad_o", pad_o, '0);
        cmp("t6_read", pins_read, '0);
        cmp("t6_pend", irq_pending, '0);
        cmp("t6_irq", W'(irq), W'(1'b0));
        io_reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            pad_i            = pad_i ^ W'($urandom & $urandom & $urandom);
            pins_write       = W'($urandom);
            pins_writeEnable = W'($urandom);
            irq_clear        = W'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 99) == 0) cfg_openDrain = W'($urandom);
            if ($urandom_range(0, 49) == 0) cfg_filtEn    = W'($urandom);
            if ($urandom_range(0, 59) == 0) cfg_filtLen   = FB'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) cfg_riseEn    = W'($urandom);
            if ($urandom_range(0, 39) == 0) cfg_fallEn    = W'($urandom);
            io_reset = ($urandom_range(0, 299) == 0);
            step();
        end
        io_reset = 1'b0; irq_clear = '0;
        repeat (3) step();
        @(posedge io_clock);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain got=%0d exp=0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
